// File: rtl/dot_prod_acc_if.sv
// Valid/ready stream bundle for the dot-product engine: operand beats in, scaled frame results out.
interface dot_prod_acc_if #(
  parameter int DATA_WIDTH_IN = 16,
  parameter int N_PAIRS       = 4,
  parameter int ACC_WIDTH     = 48
) ();
  logic                               i_valid;
  logic                               o_ready;
  logic [DATA_WIDTH_IN*N_PAIRS-1:0]   i_data_a;
  logic [DATA_WIDTH_IN*N_PAIRS-1:0]   i_data_b;
  logic                               i_last;
  logic                               o_valid;
  logic                               i_ready;
  logic [ACC_WIDTH-1:0]               o_data;
  logic                               o_ovf;

  modport slave (
    input  i_valid, i_data_a, i_data_b, i_last, i_ready,
    output o_ready, o_valid, o_data, o_ovf
  );

  modport master (
    output i_valid, i_data_a, i_data_b, i_last, i_ready,
    input  o_ready, o_valid, o_data, o_ovf
  );
endinterface

// File: rtl/dot_prod_acc.sv
// Three-stage streaming dot-product engine: products, adder tree, then saturating
// frame accumulator with a scaled, saturated result register.
module dot_prod_acc #(
  parameter int          DATA_WIDTH_IN = 16,
  parameter int          N_PAIRS       = 4,
  parameter int          ACC_WIDTH     = 48,
  parameter int unsigned SCALE         = 9,
  parameter int          SIGNED        = 0
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  dot_prod_acc_if.slave bus
);

  localparam int          DW        = DATA_WIDTH_IN;
  localparam int          PW        = 2 * DW;
  localparam int          SW        = PW + $clog2(N_PAIRS);
  localparam int          AW        = ACC_WIDTH;
  // Wide enough for AW-bit value times a 32-bit scale plus sign, so nothing wraps before clamping.
  localparam int          MW        = AW + 34;
  localparam bit          IS_SIGNED = (SIGNED != 32'sd0);
  localparam logic [31:0] SCALE_C   = 32'(SCALE);

  function automatic logic [PW-1:0] mul_op(input logic [DW-1:0] a, input logic [DW-1:0] b);
    logic signed [PW-1:0] ea;
    logic signed [PW-1:0] eb;
    ea = IS_SIGNED ? {{(PW-DW){a[DW-1]}}, a} : {{(PW-DW){1'b0}}, a};
    eb = IS_SIGNED ? {{(PW-DW){b[DW-1]}}, b} : {{(PW-DW){1'b0}}, b};
    return ea * eb;
  endfunction

  function automatic logic [SW-1:0] ext_prod(input logic [PW-1:0] p);
    return IS_SIGNED ? {{(SW-PW){p[PW-1]}}, p} : {{(SW-PW){1'b0}}, p};
  endfunction

  function automatic logic signed [MW-1:0] ext_sum(input logic [SW-1:0] s);
    return IS_SIGNED ? {{(MW-SW){s[SW-1]}}, s} : {{(MW-SW){1'b0}}, s};
  endfunction

  function automatic logic signed [MW-1:0] ext_acc(input logic [AW-1:0] v);
    return IS_SIGNED ? {{(MW-AW){v[AW-1]}}, v} : {{(MW-AW){1'b0}}, v};
  endfunction

  // Returns {saturated, clamped AW-bit value}.
  function automatic logic [AW:0] sat_fit(input logic signed [MW-1:0] v);
    logic [AW:0] r;
    if (IS_SIGNED) begin
      if (v[MW-1:AW-1] == {(MW-AW+1){v[MW-1]}}) begin
        r = {1'b0, v[AW-1:0]};
      end else if (v[MW-1]) begin
        r = {1'b1, 1'b1, {(AW-1){1'b0}}};
      end else begin
        r = {1'b1, 1'b0, {(AW-1){1'b1}}};
      end
    end else begin
      if (v[MW-1:AW] == {(MW-AW){1'b0}}) begin
        r = {1'b0, v[AW-1:0]};
      end else begin
        r = {1'b1, {AW{1'b1}}};
      end
    end
    return r;
  endfunction

  logic                        adv_s;
  logic                        s1_valid_q, s1_valid_d;
  logic                        s1_last_q,  s1_last_d;
  logic [N_PAIRS-1:0][PW-1:0]  prod_q,     prod_d;
  logic                        s2_valid_q, s2_valid_d;
  logic                        s2_last_q,  s2_last_d;
  logic [SW-1:0]               s2_sum_q,   s2_sum_d;
  logic [SW-1:0]               sum_s;
  logic [AW-1:0]               acc_q,      acc_d;
  logic                        fovf_q,     fovf_d;
  logic [AW-1:0]               o_data_q,   o_data_d;
  logic                        o_ovf_q,    o_ovf_d;
  logic                        o_valid_q,  o_valid_d;
  logic [AW:0]                 add_s;
  logic [AW:0]                 mul_s;
  logic signed [MW-1:0]        scale_s;

  // The whole pipeline advances together whenever the output slot is free or being drained.
  always_comb begin
    adv_s   = !o_valid_q || bus.i_ready;
    scale_s = {{(MW-32){1'b0}}, SCALE_C};
  end

  // Stage 1: element-wise products of the accepted beat.
  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_last_d  = s1_last_q;
    prod_d     = prod_q;
    if (adv_s) begin
      s1_valid_d = bus.i_valid;
      s1_last_d  = bus.i_last;
      if (bus.i_valid) begin
        for (int k = 0; k < N_PAIRS; k++) begin
          prod_d[k] = mul_op(bus.i_data_a[k*DW +: DW], bus.i_data_b[k*DW +: DW]);
        end
      end else begin
        prod_d = prod_q;
      end
    end else begin
      s1_valid_d = s1_valid_q;
    end
  end

  // Stage 2: adder tree over the registered products.
  always_comb begin
    sum_s = {SW{1'b0}};
    for (int k = 0; k < N_PAIRS; k++) begin
      sum_s = sum_s + ext_prod(prod_q[k]);
    end
    s2_valid_d = s2_valid_q;
    s2_last_d  = s2_last_q;
    s2_sum_d   = s2_sum_q;
    if (adv_s) begin
      s2_valid_d = s1_valid_q;
      s2_last_d  = s1_last_q;
      if (s1_valid_q) begin
        s2_sum_d = sum_s;
      end else begin
        s2_sum_d = s2_sum_q;
      end
    end else begin
      s2_valid_d = s2_valid_q;
    end
  end

  // Stage 3: saturating accumulate; on the closing beat scale, clamp and publish, then clear.
  always_comb begin
    add_s    = sat_fit(ext_acc(acc_q) + ext_sum(s2_sum_q));
    mul_s    = sat_fit(ext_acc(add_s[AW-1:0]) * scale_s);
    acc_d    = acc_q;
    fovf_d   = fovf_q;
    o_data_d = o_data_q;
    o_ovf_d  = o_ovf_q;
    o_valid_d = o_valid_q;
    if (adv_s && s2_valid_q) begin
      if (s2_last_q) begin
        o_data_d  = mul_s[AW-1:0];
        o_ovf_d   = fovf_q | add_s[AW] | mul_s[AW];
        o_valid_d = 1'b1;
        acc_d     = {AW{1'b0}};
        fovf_d    = 1'b0;
      end else begin
        acc_d     = add_s[AW-1:0];
        fovf_d    = fovf_q | add_s[AW];
        o_valid_d = 1'b0;
      end
    end else if (adv_s) begin
      o_valid_d = 1'b0;
    end else begin
      o_valid_d = o_valid_q;
    end
  end

  // State registers; reset discards any partial frame and the pending result.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      s1_valid_q <= 1'b0;
      s1_last_q  <= 1'b0;
      prod_q     <= {(N_PAIRS*PW){1'b0}};
      s2_valid_q <= 1'b0;
      s2_last_q  <= 1'b0;
      s2_sum_q   <= {SW{1'b0}};
      acc_q      <= {AW{1'b0}};
      fovf_q     <= 1'b0;
      o_data_q   <= {AW{1'b0}};
      o_ovf_q    <= 1'b0;
      o_valid_q  <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_last_q  <= s1_last_d;
      prod_q     <= prod_d;
      s2_valid_q <= s2_valid_d;
      s2_last_q  <= s2_last_d;
      s2_sum_q   <= s2_sum_d;
      acc_q      <= acc_d;
      fovf_q     <= fovf_d;
      o_data_q   <= o_data_d;
      o_ovf_q    <= o_ovf_d;
      o_valid_q  <= o_valid_d;
    end
  end

  assign bus.o_ready = adv_s;
  assign bus.o_valid = o_valid_q;
  assign bus.o_data  = o_data_q;
  assign bus.o_ovf   = o_ovf_q;

endmodule

// File: tb/tb_dot_prod_acc.sv
// Drives one shared stream into unsigned/48, signed/48 and unsigned/36 engines and
// checks every result against an arithmetic frame model.
module tb_dot_prod_acc;

  typedef logic [2:0][48:0] res_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_valid, i_last, i_ready;
  logic [63:0] a_v, b_v;
  int          chk_cnt = 0, pass_cnt = 0, fail_cnt = 0;
  int          acc_cnt = 0, popped = 0;
  res_t        exp_q[$];
  logic signed [127:0] m_acc [3];
  bit          m_fovf [3];

  always #5 clk = ~clk;

  dot_prod_acc_if #(.DATA_WIDTH_IN(16), .N_PAIRS(4), .ACC_WIDTH(48)) if_u ();
  dot_prod_acc_if #(.DATA_WIDTH_IN(16), .N_PAIRS(4), .ACC_WIDTH(48)) if_s ();
  dot_prod_acc_if #(.DATA_WIDTH_IN(16), .N_PAIRS(4), .ACC_WIDTH(36)) if_n ();

  assign if_u.i_valid = i_valid;  assign if_u.i_last = i_last;  assign if_u.i_ready = i_ready;
  assign if_u.i_data_a = a_v;     assign if_u.i_data_b = b_v;
  assign if_s.i_valid = i_valid;  assign if_s.i_last = i_last;  assign if_s.i_ready = i_ready;
  assign if_s.i_data_a = a_v;     assign if_s.i_data_b = b_v;
  assign if_n.i_valid = i_valid;  assign if_n.i_last = i_last;  assign if_n.i_ready = i_ready;
  assign if_n.i_data_a = a_v;     assign if_n.i_data_b = b_v;

  dot_prod_acc #(.DATA_WIDTH_IN(16), .N_PAIRS(4), .ACC_WIDTH(48), .SCALE(9), .SIGNED(0))
    u_u (.i_clk(clk), .i_rst_n(rst_n), .bus(if_u));
  dot_prod_acc #(.DATA_WIDTH_IN(16), .N_PAIRS(4), .ACC_WIDTH(48), .SCALE(9), .SIGNED(1))
    u_s (.i_clk(clk), .i_rst_n(rst_n), .bus(if_s));
  dot_prod_acc #(.DATA_WIDTH_IN(16), .N_PAIRS(4), .ACC_WIDTH(36), .SCALE(9), .SIGNED(0))
    u_n (.i_clk(clk), .i_rst_n(rst_n), .bus(if_n));

  task automatic chk(input string tag, input logic [47:0] obs, input logic [47:0] exp);
    chk_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic signed [127:0] ext(input logic [15:0] v, input bit sgn);
    return sgn ? {{112{v[15]}}, v} : {112'd0, v};
  endfunction

  function automatic logic signed [127:0] clamp(input logic signed [127:0] v, input int accw,
                                                input bit sgn, output bit sat);
    logic signed [127:0] hi, lo;
    hi  = sgn ? ((128'sd1 <<< (accw - 1)) - 128'sd1) : ((128'sd1 <<< accw) - 128'sd1);
    lo  = sgn ? -(128'sd1 <<< (accw - 1)) : 128'sd0;
    sat = (v > hi) || (v < lo);
    return (v > hi) ? hi : ((v < lo) ? lo : v);
  endfunction

  // Mathematical frame model: exact dot product, clamped accumulate, clamped 9x result.
  task automatic model_beat();
    res_t r;
    bit sgn, s1, s2;
    int accw;
    logic signed [127:0] dot, t, m;
    r = '0;
    for (int i = 0; i < 3; i++) begin
      sgn  = (i == 1);
      accw = (i == 2) ? 36 : 48;
      dot  = 128'sd0;
      for (int k = 0; k < 4; k++) dot += ext(a_v[k*16 +: 16], sgn) * ext(b_v[k*16 +: 16], sgn);
      t = clamp(m_acc[i] + dot, accw, sgn, s1);
      if (i_last) begin
        m = clamp(t * 128'sd9, accw, sgn, s2);
        r[i] = {m_fovf[i] | s1 | s2, m[47:0]};
        m_acc[i] = 128'sd0;
        m_fovf[i] = 1'b0;
      end else begin
        m_acc[i] = t;
        m_fovf[i] = m_fovf[i] | s1;
      end
    end
    if (i_last) exp_q.push_back(r);
  endtask

  task automatic model_reset();
    exp_q.delete();
    for (int i = 0; i < 3; i++) begin
      m_acc[i] = 128'sd0;
      m_fovf[i] = 1'b0;
    end
  endtask

  // One clock: score any result handshake and any accepted beat, then return at posedge+1.
  task automatic tick();
    res_t e;
    @(negedge clk);
    if (if_u.o_valid && i_ready) begin
      chk("out_expected", {47'd0, exp_q.size() != 0}, 48'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("u_data", if_u.o_data, e[0][47:0]);
        chk("u_ovf", {47'd0, if_u.o_ovf}, {47'd0, e[0][48]});
        chk("s_data", if_s.o_data, e[1][47:0]);
        chk("s_ovf", {47'd0, if_s.o_ovf}, {47'd0, e[1][48]});
        chk("n_data", {12'd0, if_n.o_data}, e[2][47:0]);
        chk("n_ovf", {47'd0, if_n.o_ovf}, {47'd0, e[2][48]});
        popped++;
      end
    end
    if (i_valid && if_u.o_ready) begin
      model_beat();
      acc_cnt++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [63:0] a, input logic [63:0] b, input logic last);
    i_valid = 1'b1;
    a_v = a;
    b_v = b;
    i_last = last;
  endtask

  task automatic rand_beat(input logic last);
    beat({$urandom, $urandom}, {$urandom, $urandom}, last);
  endtask

  task automatic wait_valid();
    for (int n = 0; n < 20 && !if_u.o_valid; n++) tick();
    chk("wait_valid_timeout", {47'd0, if_u.o_valid}, 48'd1);
  endtask

  localparam logic [63:0] A1 = {16'd4, 16'd3, 16'd2, 16'd1};
  localparam logic [63:0] B1 = {16'd8, 16'd7, 16'd6, 16'd5};

  initial begin
    int start, pop0, prev;
    rst_n = 1'b0; i_valid = 1'b0; i_last = 1'b0; i_ready = 1'b1; a_v = '0; b_v = '0;
    model_reset();
    #12;
    chk("rst_valid", {47'd0, if_u.o_valid}, 48'd0);
    chk("rst_data", if_u.o_data, 48'd0);
    chk("rst_ovf", {47'd0, if_u.o_ovf}, 48'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rst_ready", {47'd0, if_u.o_ready}, 48'd1);

    // Single beat with two-edge latency.
    beat(A1, B1, 1'b1); tick();
    chk("t1_lat0", {47'd0, if_u.o_valid}, 48'd0);
    i_valid = 1'b0; tick();
    chk("t1_lat1", {47'd0, if_u.o_valid}, 48'd0);
    tick();
    chk("t1_lat2", {47'd0, if_u.o_valid}, 48'd1);
    chk("t1_data", if_u.o_data, 48'd630);
    chk("t1_ovf", {47'd0, if_u.o_ovf}, 48'd0);
    tick();

    // Two-beat frame with a bubble.
    beat(A1, B1, 1'b0); tick();
    i_valid = 1'b0; tick();
    beat({4{16'd1}}, {4{16'd2}}, 1'b1); tick();
    chk("t2_no_early", {47'd0, if_u.o_valid}, 48'd0);
    i_valid = 1'b0; tick();
    chk("t2_no_early2", {47'd0, if_u.o_valid}, 48'd0);
    tick();
    chk("t2_valid", {47'd0, if_u.o_valid}, 48'd1);
    chk("t2_data", if_u.o_data, 48'd702);
    tick();
    chk("t2_single", {47'd0, if_u.o_valid}, 48'd0);

    // Signed operands.
    beat({16'd0, 16'd0, 16'd0, 16'hFFFE}, {16'd0, 16'd0, 16'd0, 16'd3}, 1'b1); tick();
    i_valid = 1'b0; wait_valid();
    chk("t3_s_data", if_s.o_data, 48'hFFFF_FFFF_FFCA);
    chk("t3_s_ovf", {47'd0, if_s.o_ovf}, 48'd0);
    tick();

    // Saturation on the 36-bit engine, then a clean frame.
    beat({4{16'hFFFF}}, {4{16'hFFFF}}, 1'b1); tick();
    i_valid = 1'b0; wait_valid();
    chk("t4_n_data", {12'd0, if_n.o_data}, 48'h0_000F_FFFF_FFFF);
    chk("t4_n_ovf", {47'd0, if_n.o_ovf}, 48'd1);
    tick();
    beat(A1, B1, 1'b1); tick();
    i_valid = 1'b0; wait_valid();
    chk("t4_n_next", {12'd0, if_n.o_data}, 48'd630);
    chk("t4_n_next_ovf", {47'd0, if_n.o_ovf}, 48'd0);
    tick();

    // Backpressure over four single-beat frames.
    start = acc_cnt; pop0 = popped;
    rand_beat(1'b1);
    for (int n = 0; n < 10 && !if_u.o_valid; n++) begin
      prev = acc_cnt; tick();
      if (acc_cnt - start >= 4) i_valid = 1'b0;
      else if (acc_cnt != prev) rand_beat(1'b1);
    end
    chk("t5_first_valid", {47'd0, if_u.o_valid}, 48'd1);
    i_ready = 1'b0;
    for (int n = 0; n < 5; n++) begin
      tick();
      chk("t5_ready_low", {47'd0, if_u.o_ready}, 48'd0);
      chk("t5_valid_held", {47'd0, if_u.o_valid}, 48'd1);
      chk("t5_data_held", if_u.o_data, (exp_q.size() != 0) ? exp_q[0][0][47:0] : 48'hDEAD);
    end
    i_ready = 1'b1;
    for (int n = 0; n < 30 && !((acc_cnt - start >= 4) && exp_q.size() == 0); n++) begin
      prev = acc_cnt; tick();
      if (acc_cnt - start >= 4) i_valid = 1'b0;
      else if (acc_cnt != prev) rand_beat(1'b1);
    end
    chk("t5_results", 48'(popped - pop0), 48'd4);

    // Asynchronous reset in the middle of a frame with a result pending.
    beat(A1, B1, 1'b1); tick();
    beat({4{16'd1}}, {4{16'd1}}, 1'b0); tick();
    i_valid = 1'b0; tick();
    i_ready = 1'b0;
    chk("t6_pending", {47'd0, if_u.o_valid}, 48'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_valid_clr", {47'd0, if_u.o_valid}, 48'd0);
    chk("t6_data_clr", if_u.o_data, 48'd0);
    model_reset();
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    i_ready = 1'b1;
    beat(A1, B1, 1'b1); tick();
    i_valid = 1'b0; wait_valid();
    chk("t6_clean", if_u.o_data, 48'd630);
    chk("t6_clean_ovf", {47'd0, if_u.o_ovf}, 48'd0);
    tick();

    // Random frames, bubbles and backpressure.
    for (int n = 0; n < 400; n++) begin
      i_valid = ($urandom % 4) != 0;
      i_last  = ($urandom % 3) == 0;
      a_v = ($urandom % 6 == 0) ? {4{16'h8000}} : {$urandom, $urandom};
      b_v = ($urandom % 6 == 0) ? {4{16'hFFFF}} : {$urandom, $urandom};
      i_ready = ($urandom % 4) != 0;
      tick();
    end
    i_valid = 1'b0; i_ready = 1'b1;
    for (int n = 0; n < 10; n++) tick();
    chk("drain_empty", 48'(exp_q.size()), 48'd0);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
